// File: rtl/tag_stream_conditioner.sv
// Tag stream conditioner: per-channel enable filter and skew delay in front of the measurement block.
// Optional macro TAG_CONDITIONER_COMPACT_EN adds a third stage that packs surviving lanes toward lane 0.
module tag_stream_conditioner #(
   parameter int WORD_WIDTH  = 4,
   parameter int DELAY_WIDTH = 24
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           s_axis_tvalid,
   output logic                           s_axis_tready,
   input  logic [64*WORD_WIDTH-1:0]       s_axis_tagtime,
   input  logic signed [6*WORD_WIDTH-1:0] s_axis_channel,
   input  logic [WORD_WIDTH-1:0]          s_axis_tkeep,
   input  logic [63:0]                    lowest_time_bound,
   input  logic [35:0]                    chan_enable,
   input  logic                           cfg_we,
   input  logic [5:0]                     cfg_addr,
   input  logic [DELAY_WIDTH-1:0]         cfg_delay,
   input  logic                           clear_count,
   output logic                           m_axis_tvalid,
   output logic [64*WORD_WIDTH-1:0]       m_axis_tagtime,
   output logic signed [6*WORD_WIDTH-1:0] m_axis_channel,
   output logic [WORD_WIDTH-1:0]          m_axis_tkeep,
   output logic [63:0]                    m_lowest_time_bound,
   output logic [31:0]                    dropped_count
);

   localparam int N_CH = 36;
   localparam int CW   = $clog2(WORD_WIDTH + 1);

   function automatic logic ch_valid(input logic signed [5:0] c);
      return ((c >= 6'sd1) && (c <= 6'sd18)) || ((c <= -6'sd1) && (c >= -6'sd18));
   endfunction

   // rising edges 1..18 -> 0..17, falling edges -1..-18 -> 18..35
   function automatic logic [5:0] ch_index(input logic signed [5:0] c);
      logic [5:0] mag;
      mag = $unsigned(-c);
      return (c > 6'sd0) ? $unsigned(c) - 6'd1 : 6'd17 + mag;
   endfunction

   logic [DELAY_WIDTH-1:0] delay_tab [N_CH];

   logic signed [5:0]      ch_in  [WORD_WIDTH];
   logic [63:0]            tag_in [WORD_WIDTH];
   logic [5:0]             idx_c  [WORD_WIDTH];
   logic [DELAY_WIDTH-1:0] dly_c  [WORD_WIDTH];
   logic [WORD_WIDTH-1:0]  ch_ok, keep_c, drop_c;
   logic [CW-1:0]          drop_n;
   logic [31:0]            drop_cnt;
   logic [32:0]            cnt_sum;

   logic                   v1;
   logic [WORD_WIDTH-1:0]  keep1;
   logic [63:0]            tag1 [WORD_WIDTH];
   logic signed [5:0]      ch1  [WORD_WIDTH];
   logic [DELAY_WIDTH-1:0] dly1 [WORD_WIDTH];
   logic [63:0]            ltb1;

   logic                   v2;
   logic [WORD_WIDTH-1:0]  keep2;
   logic [63:0]            sum2 [WORD_WIDTH];
   logic signed [5:0]      ch2  [WORD_WIDTH];
   logic [63:0]            ltb2;

   logic                   v_o;
   logic [WORD_WIDTH-1:0]  keep_o;
   logic [63:0]            tag_o [WORD_WIDTH];
   logic signed [5:0]      ch_o  [WORD_WIDTH];
   logic [63:0]            ltb_o;

   assign s_axis_tready = ~rst;

   always_comb begin
      drop_n = '0;
      for (int i = 0; i < WORD_WIDTH; i++) begin
         ch_in[i]  = s_axis_channel[6*i +: 6];
         tag_in[i] = s_axis_tagtime[64*i +: 64];
         ch_ok[i]  = ch_valid(ch_in[i]);
         idx_c[i]  = ch_ok[i] ? ch_index(ch_in[i]) : 6'd0;
         keep_c[i] = s_axis_tkeep[i] & ch_ok[i] & chan_enable[idx_c[i]];
         dly_c[i]  = ch_ok[i] ? delay_tab[idx_c[i]] : '0;
         drop_c[i] = s_axis_tvalid & s_axis_tkeep[i] & ~keep_c[i];
         drop_n    = drop_n + CW'(drop_c[i]);
      end
   end

   // nonblocking write: a word sampled in the write cycle still sees the old delay
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < N_CH; k++) delay_tab[k] <= '0;
      end else if (cfg_we && (cfg_addr < 6'd36)) begin
         delay_tab[cfg_addr] <= cfg_delay;
      end
   end

   assign cnt_sum = {1'b0, drop_cnt} + 33'(drop_n);

   always_ff @(posedge clk) begin
      if (rst || clear_count)
         drop_cnt <= '0;
      else if (cnt_sum[32])
         drop_cnt <= '1;
      else
         drop_cnt <= cnt_sum[31:0];
   end

   assign dropped_count = drop_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         v1    <= 1'b0;
         keep1 <= '0;
         ltb1  <= '0;
         for (int i = 0; i < WORD_WIDTH; i++) begin
            tag1[i] <= '0;
            ch1[i]  <= '0;
            dly1[i] <= '0;
         end
      end else begin
         v1    <= s_axis_tvalid;
         keep1 <= keep_c;
         ltb1  <= lowest_time_bound;
         for (int i = 0; i < WORD_WIDTH; i++) begin
            tag1[i] <= tag_in[i];
            ch1[i]  <= ch_in[i];
            dly1[i] <= dly_c[i];
         end
      end
   end

   // data lanes only advance on valid words so idle cycles hold the last word
   always_ff @(posedge clk) begin
      if (rst) begin
         v2    <= 1'b0;
         keep2 <= '0;
         ltb2  <= '0;
         for (int i = 0; i < WORD_WIDTH; i++) begin
            sum2[i] <= '0;
            ch2[i]  <= '0;
         end
      end else begin
         v2    <= v1;
         keep2 <= v1 ? keep1 : '0;
         ltb2  <= ltb1;
         if (v1) begin
            for (int i = 0; i < WORD_WIDTH; i++) begin
               sum2[i] <= tag1[i] + 64'(dly1[i]);
               ch2[i]  <= ch1[i];
            end
         end
      end
   end

`ifdef TAG_CONDITIONER_COMPACT_EN
   logic [CW-1:0]          rank [WORD_WIDTH];
   logic [CW-1:0]          n_keep;
   logic [WORD_WIDTH-1:0]  pk_keep;
   logic [63:0]            pk_tag [WORD_WIDTH];
   logic signed [5:0]      pk_ch  [WORD_WIDTH];

   logic                   v3;
   logic [WORD_WIDTH-1:0]  keep3;
   logic [63:0]            tag3 [WORD_WIDTH];
   logic signed [5:0]      ch3  [WORD_WIDTH];
   logic [63:0]            ltb3;

   // a surviving lane's destination is the number of survivors below it
   always_comb begin
      n_keep = '0;
      for (int i = 0; i < WORD_WIDTH; i++) begin
         rank[i] = n_keep;
         n_keep  = n_keep + CW'(keep2[i]);
      end
      for (int j = 0; j < WORD_WIDTH; j++) begin
         pk_tag[j]  = '0;
         pk_ch[j]   = '0;
         pk_keep[j] = (CW'(j) < n_keep);
         for (int i = 0; i < WORD_WIDTH; i++) begin
            if (keep2[i] && (rank[i] == CW'(j))) begin
               pk_tag[j] = sum2[i];
               pk_ch[j]  = ch2[i];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v3    <= 1'b0;
         keep3 <= '0;
         ltb3  <= '0;
         for (int i = 0; i < WORD_WIDTH; i++) begin
            tag3[i] <= '0;
            ch3[i]  <= '0;
         end
      end else begin
         v3    <= v2;
         keep3 <= v2 ? pk_keep : '0;
         ltb3  <= ltb2;
         if (v2) begin
            for (int i = 0; i < WORD_WIDTH; i++) begin
               tag3[i] <= pk_tag[i];
               ch3[i]  <= pk_ch[i];
            end
         end
      end
   end

   always_comb begin
      v_o    = v3;
      keep_o = keep3;
      ltb_o  = ltb3;
      for (int i = 0; i < WORD_WIDTH; i++) begin
         tag_o[i] = tag3[i];
         ch_o[i]  = ch3[i];
      end
   end
`else
   always_comb begin
      v_o    = v2;
      keep_o = keep2;
      ltb_o  = ltb2;
      for (int i = 0; i < WORD_WIDTH; i++) begin
         tag_o[i] = sum2[i];
         ch_o[i]  = ch2[i];
      end
   end
`endif

   assign m_axis_tvalid       = v_o;
   assign m_axis_tkeep        = keep_o;
   assign m_lowest_time_bound = ltb_o;

   for (genvar g = 0; g < WORD_WIDTH; g++) begin : g_pack
      assign m_axis_tagtime[64*g +: 64] = tag_o[g];
      assign m_axis_channel[6*g +: 6]   = ch_o[g];
   end

endmodule

// File: tb/tb_tag_stream_conditioner.sv
// Directed bench for tag_stream_conditioner; honours TAG_CONDITIONER_COMPACT_EN for latency and lane packing.
module tb_tag_stream_conditioner;

   localparam int W  = 4;
   localparam int DW = 24;
`ifdef TAG_CONDITIONER_COMPACT_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic                  clk;
   logic                  rst;
   logic                  s_axis_tvalid;
   logic                  s_axis_tready;
   logic [64*W-1:0]       s_axis_tagtime;
   logic signed [6*W-1:0] s_axis_channel;
   logic [W-1:0]          s_axis_tkeep;
   logic [63:0]           lowest_time_bound;
   logic [35:0]           chan_enable;
   logic                  cfg_we;
   logic [5:0]            cfg_addr;
   logic [DW-1:0]         cfg_delay;
   logic                  clear_count;
   logic                  m_axis_tvalid;
   logic [64*W-1:0]       m_axis_tagtime;
   logic signed [6*W-1:0] m_axis_channel;
   logic [W-1:0]          m_axis_tkeep;
   logic [63:0]           m_lowest_time_bound;
   logic [31:0]           dropped_count;

   tag_stream_conditioner #(.WORD_WIDTH(W), .DELAY_WIDTH(DW)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .s_axis_tvalid       (s_axis_tvalid),
      .s_axis_tready       (s_axis_tready),
      .s_axis_tagtime      (s_axis_tagtime),
      .s_axis_channel      (s_axis_channel),
      .s_axis_tkeep        (s_axis_tkeep),
      .lowest_time_bound   (lowest_time_bound),
      .chan_enable         (chan_enable),
      .cfg_we              (cfg_we),
      .cfg_addr            (cfg_addr),
      .cfg_delay           (cfg_delay),
      .clear_count         (clear_count),
      .m_axis_tvalid       (m_axis_tvalid),
      .m_axis_tagtime      (m_axis_tagtime),
      .m_axis_channel      (m_axis_channel),
      .m_axis_tkeep        (m_axis_tkeep),
      .m_lowest_time_bound (m_lowest_time_bound),
      .dropped_count       (dropped_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_bad = 0;
   logic [63:0] e_tag [W];
   logic [5:0]  e_ch  [W];

   task automatic check_val(input string nm, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, obs, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic idle();
      s_axis_tvalid = 1'b0;
      s_axis_tkeep  = '0;
   endtask

   task automatic put_word(input logic [63:0] t0, t1, t2, t3,
                           input int c0, c1, c2, c3, input logic [3:0] keep);
      s_axis_tvalid  = 1'b1;
      s_axis_tagtime = {t3, t2, t1, t0};
      s_axis_channel = {c3[5:0], c2[5:0], c1[5:0], c0[5:0]};
      s_axis_tkeep   = keep;
   endtask

   task automatic set_exp(input logic [63:0] t0, t1, t2, t3, input int c0, c1, c2, c3);
      e_tag[0] = t0; e_tag[1] = t1; e_tag[2] = t2; e_tag[3] = t3;
      e_ch[0] = c0[5:0]; e_ch[1] = c1[5:0]; e_ch[2] = c2[5:0]; e_ch[3] = c3[5:0];
   endtask

   task automatic check_word(input string nm, input logic [3:0] keep, input logic [3:0] lanes);
      check_val({nm, "_tvalid"}, 64'(m_axis_tvalid), 64'd1);
      check_val({nm, "_tkeep"}, 64'(m_axis_tkeep), 64'(keep));
      for (int i = 0; i < W; i++) begin
         if (lanes[i]) begin
            check_val($sformatf("%s_tag%0d", nm, i), m_axis_tagtime[64*i +: 64], e_tag[i]);
            check_val($sformatf("%s_ch%0d", nm, i), 64'(m_axis_channel[6*i +: 6]), 64'(e_ch[i]));
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int d;
      logic [63:0] exp_ltb;

      rst = 1'b1;
      s_axis_tvalid = 1'b0;
      s_axis_tagtime = '0;
      s_axis_channel = '0;
      s_axis_tkeep = '0;
      lowest_time_bound = '0;
      chan_enable = '1;
      cfg_we = 1'b0;
      cfg_addr = '0;
      cfg_delay = '0;
      clear_count = 1'b0;
      step(3);

      // reset state
      check_val("rst_tready", 64'(s_axis_tready), 64'd0);
      check_val("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      check_val("rst_tkeep", 64'(m_axis_tkeep), 64'd0);
      check_val("rst_tag0", m_axis_tagtime[63:0], 64'd0);
      check_val("rst_ch0", 64'(m_axis_channel[5:0]), 64'd0);
      check_val("rst_ltb", m_lowest_time_bound, 64'd0);
      check_val("rst_drop", 64'(dropped_count), 64'd0);
      rst = 1'b0;
      #1;
      check_val("run_tready", 64'(s_axis_tready), 64'd1);
      step(1);

      // 1: pass-through, all channels enabled, zero delays
      put_word(100, 200, 300, 400, 1, -1, 18, -18, 4'b1111);
      step(1);
      idle();
      step(LAT - 1);
      set_exp(100, 200, 300, 400, 1, -1, 18, -18);
      check_word("t1", 4'b1111, 4'b1111);
      check_val("t1_drop", 64'(dropped_count), 64'd0);
      step(1);
      check_val("t1_idle_tvalid", 64'(m_axis_tvalid), 64'd0);
      check_val("t1_idle_tkeep", 64'(m_axis_tkeep), 64'd0);
      check_val("t1_idle_hold", m_axis_tagtime[63:0], 64'd100);

      // 2: channel 1 (index 0) disabled
      chan_enable = 36'hF_FFFF_FFFE;
      put_word(10, 20, 30, 40, 1, 2, 1, 3, 4'b1111);
      step(1);
      idle();
      step(LAT - 1);
`ifdef TAG_CONDITIONER_COMPACT_EN
      set_exp(20, 40, 0, 0, 2, 3, 0, 0);
      check_word("t2", 4'b0011, 4'b1111);
`else
      set_exp(10, 20, 30, 40, 1, 2, 1, 3);
      check_word("t2", 4'b1010, 4'b1111);
`endif
      check_val("t2_drop", 64'(dropped_count), 64'd2);
      chan_enable = '1;

      // 3: delay write to channel -1 racing a word, then wraparound
      cfg_we = 1'b1;
      cfg_addr = 6'd18;
      cfg_delay = 24'd1000;
      put_word(5000, 0, 0, 0, -1, 1, 1, 1, 4'b0001);
      step(1);
      cfg_we = 1'b0;
      put_word(64'hFFFF_FFFF_FFFF_FE0C, 700, 1, 9, -1, 2, -1, 1, 4'b1111);
      step(1);
      idle();
      step(LAT - 2);
      set_exp(5000, 0, 0, 0, -1, 0, 0, 0);
      check_word("t3_old", 4'b0001, 4'b0001);
      step(1);
      set_exp(500, 700, 1001, 9, -1, 2, -1, 1);
      check_word("t3_new", 4'b1111, 4'b1111);
      check_val("t3_drop", 64'(dropped_count), 64'd2);

      // 4: invalid channels always dropped
      put_word(1, 2, 3, 4, 0, 19, -19, 5, 4'b1111);
      step(1);
      idle();
      step(LAT - 1);
`ifdef TAG_CONDITIONER_COMPACT_EN
      set_exp(4, 0, 0, 0, 5, 0, 0, 0);
      check_word("t4", 4'b0001, 4'b1111);
`else
      set_exp(1, 2, 3, 4, 0, 19, -19, 5);
      check_word("t4", 4'b1000, 4'b1111);
`endif
      check_val("t4_drop", 64'(dropped_count), 64'd5);

      // 4b: saturation, clear, invalid word not counted
      force dut.drop_cnt = 32'hFFFF_FFFC;
      step(1);
      release dut.drop_cnt;
      put_word(0, 0, 0, 0, 0, 0, 0, 0, 4'b0111);
      step(1);
      idle();
      check_val("sat_exact", 64'(dropped_count), 64'hFFFF_FFFF);
      put_word(0, 0, 0, 0, 0, 0, 0, 0, 4'b1111);
      step(1);
      idle();
      check_val("sat_hold", 64'(dropped_count), 64'hFFFF_FFFF);
      put_word(0, 0, 0, 0, 0, 0, 0, 0, 4'b1111);
      clear_count = 1'b1;
      step(1);
      clear_count = 1'b0;
      idle();
      check_val("clear", 64'(dropped_count), 64'd0);
      put_word(0, 0, 0, 0, 0, 0, 0, 0, 4'b0001);
      step(1);
      check_val("after_clear", 64'(dropped_count), 64'd1);
      s_axis_tvalid = 1'b0;
      s_axis_tkeep = 4'b1111;
      step(1);
      idle();
      check_val("novalid_nocount", 64'(dropped_count), 64'd1);
      step(LAT);

      // 5: lowest_time_bound ramp and an all-filtered valid word
      s_axis_channel = {6'd1, 6'd1, 6'd1, 6'd1};
      for (int k = 0; k < 6; k++) begin
         lowest_time_bound = (k < 3) ? 64'((k + 1) * 10) : 64'd30;
         s_axis_tvalid = (k == 1);
         s_axis_tkeep = '0;
         step(1);
         d = k + 1 - LAT;
         exp_ltb = (d < 0) ? 64'd0 : (d < 3) ? 64'((d + 1) * 10) : 64'd30;
         check_val($sformatf("t5_ltb%0d", k), m_lowest_time_bound, exp_ltb);
         check_val($sformatf("t5_tvalid%0d", k), 64'(m_axis_tvalid), 64'(d == 1));
         check_val($sformatf("t5_tkeep%0d", k), 64'(m_axis_tkeep), 64'd0);
      end
      idle();

      // 6: reset with words in flight
      put_word(7, 8, 9, 10, 0, 1, 1, 1, 4'b1111);
      step(1);
      rst = 1'b1;
      put_word(11, 12, 13, 14, 1, 1, 1, 1, 4'b1111);
      #1;
      check_val("t6_tready_rst", 64'(s_axis_tready), 64'd0);
      step(1);
      rst = 1'b0;
      idle();
      check_val("t6_drop", 64'(dropped_count), 64'd0);
      check_val("t6_tag0", m_axis_tagtime[63:0], 64'd0);
      check_val("t6_ltb", m_lowest_time_bound, 64'd0);
      for (int k = 0; k < LAT + 2; k++) begin
         step(1);
         check_val($sformatf("t6_flush%0d", k), 64'(m_axis_tvalid), 64'd0);
      end
      put_word(50, 0, 0, 0, -1, 1, 1, 1, 4'b0001);
      step(1);
      idle();
      step(LAT - 2);
      check_val("t6_early", 64'(m_axis_tvalid), 64'd0);
      step(1);
      set_exp(50, 0, 0, 0, -1, 0, 0, 0);
      check_word("t6_first", 4'b0001, 4'b0001);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
